// File: rtl/div8_seq_pkg.sv
// div8_seq_pkg: shared ALU divider types and constants
package div8_seq_pkg;
  localparam int DIV_W = 8;
  localparam logic [DIV_W-1:0] DIV_ZERO_QUOT = 8'hFF;
  typedef enum logic [1:0] {IDLE, CALC, FAULT} state_t;
endpackage

// File: rtl/add8.sv
// add8: 8-bit ripple-carry adder
module add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [8:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[8];
endmodule

// File: rtl/div8_seq_sub8.sv
// sub8: combinational 8-bit subtractor a - b as a + ~b + 1
module sub8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] diff,
  output logic       borrow
);
  logic cout;
  add8 u_add (.a(a), .b(~b), .cin(1'b1), .sum(diff), .cout(cout));
  assign borrow = ~cout;
endmodule

// File: rtl/div8_seq.sv
// div8_seq: iterative 8-bit unsigned restoring divider, one step per clock
module div8_seq
  import div8_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_by_zero
);
  state_t state, state_nxt;
  logic [DIV_W-1:0] r, q, d, r_nxt, q_nxt, d_nxt, quot_nxt, rem_nxt, diff;
  logic [2:0] cnt, cnt_nxt;
  logic [DIV_W:0] s;
  logic borrow, ok, done_nxt, dbz_nxt;
  assign s = {r, q[DIV_W-1]};
  sub8 u_sub (.a(s[DIV_W-1:0]), .b(d), .diff(diff), .borrow(borrow));
  // the partial remainder never reaches bit 8 after a step, so r keeps 8 bits
  assign ok = s[DIV_W] | ~borrow;
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    r_nxt = r;
    q_nxt = q;
    d_nxt = d;
    cnt_nxt = cnt;
    done_nxt = 1'b0;
    quot_nxt = quotient;
    rem_nxt = remainder;
    dbz_nxt = div_by_zero;
    case (state)
      IDLE: if (start) begin
        q_nxt = dividend;
        r_nxt = '0;
        d_nxt = divisor;
        cnt_nxt = '0;
        state_nxt = divisor == '0 ? FAULT : CALC;
      end
      CALC: begin
        r_nxt = ok ? diff : s[DIV_W-1:0];
        q_nxt = {q[DIV_W-2:0], ok};
        cnt_nxt = cnt + 3'd1;
        if (cnt == 3'd7) begin
          quot_nxt = q_nxt;
          rem_nxt = r_nxt;
          dbz_nxt = 1'b0;
          done_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      FAULT: begin
        quot_nxt = DIV_ZERO_QUOT;
        rem_nxt = q;
        dbz_nxt = 1'b1;
        done_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      r <= r_nxt;
      q <= q_nxt;
      d <= d_nxt;
      cnt <= cnt_nxt;
      done <= done_nxt;
      quotient <= quot_nxt;
      remainder <= rem_nxt;
      div_by_zero <= dbz_nxt;
    end
  end
endmodule

// File: tb/tb_div8_seq.sv
// tb_div8_seq: vector table, random ops against an arithmetic model, and timing corner cases
module tb_div8_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [7:0] quotient, remainder;
  int nchk = 0, nerr = 0;
  always #5 clk = ~clk;
  div8_seq dut (.clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero));
  typedef struct {
    logic [7:0] a, b, q, r;
    logic z;
    int lat;
  } vec_t;
  vec_t tbl[7];
  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic void model(input int a, input int b, output int q, output int r, output int z, output int lat);
    if (b == 0) begin q = 255; r = a; z = 1; lat = 2; end
    else begin q = a / b; r = a % b; z = 0; lat = 9; end
  endfunction
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int qo, output int ro, output int zo,
                       output int lat, output int bcnt);
    bit got = 0;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; bcnt = 0; qo = -1; ro = -1; zo = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) begin
        got = 1;
        qo = quotient; ro = remainder; zo = div_by_zero;
        chk("busy_low_at_done", busy, 0);
      end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask
  initial begin
    int qo, ro, zo, lat, bc, eq, er, ez, el, ndone, gap;
    tbl[0] = '{8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9};
    tbl[1] = '{8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9};
    tbl[2] = '{8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9};
    tbl[3] = '{8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9};
    tbl[4] = '{8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 9};
    tbl[5] = '{8'd100, 8'd0, 8'hFF, 8'd100, 1'b1, 2};
    tbl[6] = '{8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 9};
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].a, tbl[i].b, qo, ro, zo, lat, bc);
      chk($sformatf("vec%0d_quot", i), qo, tbl[i].q);
      chk($sformatf("vec%0d_rem", i), ro, tbl[i].r);
      chk($sformatf("vec%0d_dbz", i), zo, tbl[i].z);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_busy_cycles", i), bc, tbl[i].lat - 1);
    end
    for (int i = 0; i < 60; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      model(a, b, eq, er, ez, el);
      do_op(a, b, qo, ro, zo, lat, bc);
      chk($sformatf("rnd %0d/%0d quot", a, b), qo, eq);
      chk($sformatf("rnd %0d/%0d rem", a, b), ro, er);
      chk($sformatf("rnd %0d/%0d dbz", a, b), zo, ez);
      chk($sformatf("rnd %0d/%0d lat", a, b), lat, el);
    end
    // start pulsed mid-operation must be ignored
    @(negedge clk);
    dividend = 8'd200; divisor = 8'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0; qo = -1; ro = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) begin dividend = 8'd50; divisor = 8'd5; start = 1'b1; end
      if (i == 4) start = 1'b0;
      if (done) begin ndone++; qo = quotient; ro = remainder; end
    end
    chk("ignored_start_ndone", ndone, 1);
    chk("ignored_start_quot", qo, 28);
    chk("ignored_start_rem", ro, 4);
    // reset mid-operation aborts without done
    @(negedge clk);
    dividend = 8'd200; divisor = 8'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 4) rst = 1'b1;
    end
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_quot", quotient, 0);
    chk("midrst_rem", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    do_op(8'd81, 8'd9, qo, ro, zo, lat, bc);
    chk("post_rst_quot", qo, 9);
    chk("post_rst_rem", ro, 0);
    // back-to-back: start held across the done cycle
    do_op(8'd200, 8'd7, qo, ro, zo, lat, bc);
    dividend = 8'd77; divisor = 8'd10; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    gap = 0; qo = -1; ro = -1;
    for (int i = 1; i <= 20 && gap == 0; i++) begin
      @(negedge clk);
      if (done) begin gap = i; qo = quotient; ro = remainder; end
    end
    chk("b2b_gap", gap, 9);
    chk("b2b_quot", qo, 7);
    chk("b2b_rem", ro, 7);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
